// File: rtl/rfid_cmd_pkg.sv
// rfid_cmd_pkg: definitions shared by the command frame receiver and the opcode decoder.
//   - frame geometry (FRAME_BITS, DATA_BITS) and the CCITT CRC-16 polynomial
//   - opcode class codes carried in op_code_bus[15:12]
//   - receiver FSM state encoding
//   - cmd_frame_t: field view of the 48-bit shift register
//   - crc16_step(): one MSB-first serial CRC update
package rfid_cmd_pkg;

  localparam int FRAME_BITS = 48;
  localparam int DATA_BITS  = 32;

  localparam logic [15:0] CRC16_POLY = 16'h1021;

  typedef logic [3:0] op_class_t;
  localparam op_class_t CONFIG_LOOKUP  = 4'h1;
  localparam op_class_t CONFIG_SENSOR  = 4'h2;
  localparam op_class_t DEFAULT_SENSOR = 4'h3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  typedef struct packed {
    logic [15:0] op_code;
    logic [15:0] user_data;
    logic [15:0] crc;
  } cmd_frame_t;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: serial CCITT CRC-16 register, one bit per enabled cycle, MSB first.
// Ports:
//   clock   in   system clock
//   reset   in   asynchronous active-high reset, loads PRESET
//   init    in   reload PRESET (wins over en)
//   en      in   fold bit_in into the register this cycle
//   bit_in  in   serial data bit
//   crc     out  current register value
module crc16_serial
  import rfid_cmd_pkg::*;
#(
  parameter logic [15:0] PRESET = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init) begin
      crc_d = PRESET;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      crc_q <= PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: deserialises a 48-bit command frame {opcode, user data, CRC-16},
// checks the CRC and hands good frames to the opcode decoder with a 1-cycle strobe.
// Ports:
//   clock, reset       system clock, asynchronous active-high reset
//   frame_start        delimiter pulse, (re)starts frame reception
//   bit_in, bit_valid  serial bit stream, MSB first
//   op_code_bus        opcode word of last good frame
//   user_data_bus      user data word of last good frame
//   frame_valid        1-cycle pulse, new good frame on the buses
//   crc_error          1-cycle pulse, complete frame failed CRC
//   timeout_error      1-cycle pulse, bit gap too long inside a frame
//   busy               high while receiving or checking
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | waiting for frame_start, bit_valid ignored
// ST_SHIFT | collecting bits, CRC over first 32, gap timer running
// ST_CHECK | all 48 bits in, compare CRC and emit result pulse
module cmd_frame_rx
  import rfid_cmd_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic [15:0] CRC_PRESET     = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] op_code_bus,
  output logic [15:0] user_data_bus,
  output logic        frame_valid,
  output logic        crc_error,
  output logic        timeout_error,
  output logic        busy
);

  localparam logic [5:0] LAST_BIT_IDX = 6'(FRAME_BITS - 1);
  localparam logic [5:0] CRC_BIT_CNT  = 6'(DATA_BITS);

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [47:0] sr_q, sr_d;
  logic [15:0] op_q, op_d;
  logic [15:0] ud_q, ud_d;
  logic        fv_q, fv_d;
  logic        ce_q, ce_d;
  logic        te_q, te_d;

  logic        crc_init;
  logic        crc_en;
  logic [15:0] crc_calc;
  cmd_frame_t  fields;

  assign fields = sr_q;

  crc16_serial #(
    .PRESET(CRC_PRESET)
  ) u_crc (
    .clock (clock),
    .reset (reset),
    .init  (crc_init),
    .en    (crc_en),
    .bit_in(bit_in),
    .crc   (crc_calc)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    timer_d  = timer_q;
    sr_d     = sr_q;
    op_d     = op_q;
    ud_d     = ud_q;
    fv_d     = 1'b0;
    ce_d     = 1'b0;
    te_d     = 1'b0;
    crc_init = 1'b0;
    crc_en   = 1'b0;

    // A delimiter restarts reception from any state; a bit in the same
    // cycle belongs to nothing and is dropped.
    if (frame_start) begin
      state_d  = ST_SHIFT;
      cnt_d    = 6'd0;
      timer_d  = 16'd0;
      crc_init = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bit_valid) begin
            sr_d    = {sr_q[46:0], bit_in};
            cnt_d   = cnt_q + 6'd1;
            timer_d = 16'd0;
            // Only opcode and user data are covered; the trailing 16 bits are the CRC itself.
            crc_en  = (cnt_q < CRC_BIT_CNT);
            if (cnt_q == LAST_BIT_IDX) begin
              state_d = ST_CHECK;
            end
          end else if (timer_q == TIMEOUT_CYCLES) begin
            te_d    = 1'b1;
            timer_d = 16'd0;
            state_d = ST_IDLE;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        ST_CHECK: begin
          // Transmitted CRC is the ones' complement of the running register.
          if (fields.crc == ~crc_calc) begin
            fv_d = 1'b1;
            op_d = fields.op_code;
            ud_d = fields.user_data;
          end else begin
            ce_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      timer_q <= 16'd0;
      sr_q    <= 48'd0;
      op_q    <= 16'd0;
      ud_q    <= 16'd0;
      fv_q    <= 1'b0;
      ce_q    <= 1'b0;
      te_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      sr_q    <= sr_d;
      op_q    <= op_d;
      ud_q    <= ud_d;
      fv_q    <= fv_d;
      ce_q    <= ce_d;
      te_q    <= te_d;
    end
  end

  assign op_code_bus   = op_q;
  assign user_data_bus = ud_q;
  assign frame_valid   = fv_q;
  assign crc_error     = ce_q;
  assign timeout_error = te_q;
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_cmd_frame_rx.sv
module tb_cmd_frame_rx;

  localparam logic [15:0] TMO = 16'd16;
  localparam int K_FRAME = 0;
  localparam int K_CRC   = 1;
  localparam int K_TMO   = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic [15:0] op_code_bus;
  logic [15:0] user_data_bus;
  logic        frame_valid;
  logic        crc_error;
  logic        timeout_error;
  logic        busy;

  cmd_frame_rx #(
    .TIMEOUT_CYCLES(TMO),
    .CRC_PRESET    (16'hFFFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .frame_start  (frame_start),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .op_code_bus  (op_code_bus),
    .user_data_bus(user_data_bus),
    .frame_valid  (frame_valid),
    .crc_error    (crc_error),
    .timeout_error(timeout_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [15:0] op;
    logic [15:0] ud;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: last good frame as seen by the decoder.
  logic [15:0] model_op = 16'h0000;
  logic [15:0] model_ud = 16'h0000;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Transmitted CRC field for a 32-bit payload: CCITT, preset FFFF, MSB first, inverted.
  function automatic logic [15:0] frame_crc(input logic [31:0] data);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 31; i >= 0; i--) begin
      if (r[15] ^ data[i]) r = (r << 1) ^ 16'h1021;
      else                 r = r << 1;
    end
    return ~r;
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse kind=%0d expected at cycle %0d, none by cycle %0d",
                 exp_q[0].kind, exp_q[0].cyc, cyc);
        exp_q.delete(0);
      end
      if (frame_valid || crc_error || timeout_error) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse fv=%0b ce=%0b te=%0b at cycle %0d, none expected",
                   frame_valid, crc_error, timeout_error, cyc);
        end else begin
          exp_t e;
          logic [2:0] want;
          e = exp_q.pop_front();
          want = (e.kind == K_FRAME) ? 3'b100 : (e.kind == K_CRC) ? 3'b010 : 3'b001;
          chk("pulse_kind", {45'd0, frame_valid, crc_error, timeout_error}, {45'd0, want});
          chk("pulse_cycle", 48'(cyc), 48'(e.cyc));
          chk("op_code_bus", {32'd0, op_code_bus}, {32'd0, e.op});
          chk("user_data_bus", {32'd0, user_data_bus}, {32'd0, e.ud});
          chk("busy_after", {47'd0, busy}, 48'd0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input bit with_junk_bit);
    frame_start = 1'b1;
    bit_valid   = with_junk_bit;
    bit_in      = 1'b1;
    tick();
    frame_start = 1'b0;
    bit_valid   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  // Full frame from delimiter to result; flip corrupts the CRC field.
  task automatic send_frame(input logic [15:0] op, input logic [15:0] ud,
                            input logic [15:0] flip, input int gmin, input int gmax,
                            input bit junk);
    logic [47:0] bits;
    exp_t e;
    bits = {op, ud, frame_crc({op, ud}) ^ flip};
    start(junk);
    for (int i = 47; i >= 0; i--) begin
      send_bit(bits[i]);
      if (i == 0) begin
        if (flip == 16'h0000) begin
          model_op = op;
          model_ud = ud;
          e.kind = K_FRAME;
        end else begin
          e.kind = K_CRC;
        end
        e.op  = model_op;
        e.ud  = model_ud;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end else begin
        idle(int'($urandom_range(gmax, gmin)));
      end
    end
    idle(3);
  endtask

  task automatic send_partial(input int n, input int gmax);
    start(1'b0);
    for (int i = 0; i < n; i++) begin
      send_bit(1'($urandom));
      idle(int'($urandom_range(gmax, 0)));
    end
  endtask

  task automatic timeout_frame(input int n);
    exp_t e;
    send_partial(n, 0);
    e.kind = K_TMO;
    e.op   = model_op;
    e.ud   = model_ud;
    e.cyc  = cyc + int'(TMO) + 1;
    exp_q.push_back(e);
    idle(int'(TMO) + 5);
  endtask

  initial begin
    int r;
    logic [15:0] fl;

    // reset state
    idle(2);
    chk("rst_op", {32'd0, op_code_bus}, 48'd0);
    chk("rst_ud", {32'd0, user_data_bus}, 48'd0);
    chk("rst_pulses", {45'd0, frame_valid, crc_error, timeout_error}, 48'd0);
    chk("rst_busy", {47'd0, busy}, 48'd0);
    reset = 1'b0;
    idle(2);

    // 1: good frame, back to back bits
    start(1'b0);
    chk("busy_in_frame", {47'd0, busy}, 48'd1);
    idle(1);
    send_frame(16'h1234, 16'hABCD, 16'h0000, 0, 0, 1'b0);
    // 2: CRC bit 0 flipped
    send_frame(16'h1234, 16'hABCD, 16'h0001, 0, 0, 1'b0);
    // 3: gaps of 3, then a stalled frame
    send_frame(16'h1234, 16'hABCD, 16'h0000, 3, 3, 1'b0);
    timeout_frame(20);
    chk("busy_after_timeout", {47'd0, busy}, 48'd0);
    // 4: restart after 30 bits (bit_valid alongside delimiter must be dropped)
    send_partial(30, 1);
    send_frame(16'h2001, 16'h00FF, 16'h0000, 0, 1, 1'b1);

    // 5: asynchronous reset mid-frame
    send_partial(40, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_op", {32'd0, op_code_bus}, 48'd0);
    chk("async_rst_ud", {32'd0, user_data_bus}, 48'd0);
    chk("async_rst_busy", {47'd0, busy}, 48'd0);
    chk("async_rst_pulses", {45'd0, frame_valid, crc_error, timeout_error}, 48'd0);
    model_op = 16'h0000;
    model_ud = 16'h0000;
    idle(2);
    reset = 1'b0;
    idle(1);
    send_frame(16'h3C5A, 16'h0F0F, 16'h0000, 0, 2, 1'b0);

    // 6: bit_valid activity with no delimiter
    for (int i = 0; i < 20; i++) begin
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
      tick();
      chk("idle_busy", {47'd0, busy}, 48'd0);
    end
    bit_valid = 1'b0;
    idle(2);

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(9, 0));
      if (r <= 5) begin
        send_frame(16'($urandom), 16'($urandom), 16'h0000, 0, 2, 1'($urandom));
      end else if (r <= 7) begin
        fl = 16'($urandom_range(65535, 1));
        send_frame(16'($urandom), 16'($urandom), fl, 0, 2, 1'b0);
      end else if (r == 8) begin
        timeout_frame(int'($urandom_range(47, 0)));
      end else begin
        send_partial(int'($urandom_range(47, 1)), 2);
        send_frame(16'($urandom), 16'($urandom), 16'h0000, 0, 1, 1'b0);
      end
    end

    idle(int'(TMO) + 10);
    chk("queue_drained", 48'(exp_q.size()), 48'd0);
    chk("final_op", {32'd0, op_code_bus}, {32'd0, model_op});
    chk("final_ud", {32'd0, user_data_bus}, {32'd0, model_ud});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
